// File: rtl/st_multi_xfer_if.sv
// Command, data-memory and register-file signals of the st_multi_xfer engine.
// master: the transfer engine; slave: the surrounding core, memory and register file.
interface st_multi_xfer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              start;
  logic              is_pop;
  logic [8:0]        rlist;
  logic [ADDR_W-1:0] sp_in;
  logic [15:0]       lr_in;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] sp_out;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [2:0]        rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              pc_we;
  logic [15:0]       pc_out;

  modport master (
    input  start, is_pop, rlist, sp_in, lr_in, mem_ack, mem_rdata, rf_rdata,
    output busy, done, sp_out, err, mem_req, mem_we, mem_addr, mem_wdata,
           rf_raddr, rf_we, rf_waddr, rf_wdata, pc_we, pc_out
  );

  modport slave (
    output start, is_pop, rlist, sp_in, lr_in, mem_ack, mem_rdata, rf_rdata,
    input  busy, done, sp_out, err, mem_req, mem_we, mem_addr, mem_wdata,
           rf_raddr, rf_we, rf_waddr, rf_wdata, pc_we, pc_out
  );
endinterface

// File: rtl/st_multi_xfer.sv
// st_multi_xfer: runs a multi-register PUSH/POP as ascending word transfers on the data-memory port.
// Optional macro ST_XFER_ALIGN_CHK_EN: a start with sp_in[1:0]!=0 aborts straight to done with err=1.
module st_multi_xfer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            resetn,
  st_multi_xfer_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              is_pop_q, is_pop_d;
  logic [8:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] final_q, final_d;
  logic              err_q, err_d;

  logic [3:0]        n;
  logic [3:0]        item;
  logic              item_found;
  logic [ADDR_W-1:0] span;
  logic              misaligned;
  logic              in_xfer, in_done, is_pc, ack_wb;

  always_comb begin
    n = '0;
    for (int unsigned i = 0; i < 9; i++) n = n + {3'b000, bus.rlist[i]};
  end

  assign span = ADDR_W'(n) << 2;

  // Lowest pending bit is the current item, giving R0-first, bit-8-last order.
  always_comb begin
    item       = '0;
    item_found = 1'b0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (!item_found && mask_q[i]) begin
        item       = 4'(i);
        item_found = 1'b1;
      end
    end
  end

`ifdef ST_XFER_ALIGN_CHK_EN
  assign misaligned = |bus.sp_in[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    is_pop_d = is_pop_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    final_d  = final_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_pop_d = bus.is_pop;
          err_d    = 1'b0;
          if (misaligned) begin
            mask_d  = '0;
            addr_d  = bus.sp_in;
            final_d = bus.sp_in;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            mask_d  = bus.rlist;
            addr_d  = bus.is_pop ? bus.sp_in : bus.sp_in - span;
            final_d = bus.is_pop ? bus.sp_in + span : bus.sp_in - span;
            state_d = (n == 4'd0) ? S_DONE : S_XFER;
          end
        end
      end
      S_XFER: begin
        if (bus.mem_ack) begin
          mask_d = mask_q & ~(9'd1 << item);
          addr_d = addr_q + ADDR_W'(4);
          if (mask_d == '0) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      is_pop_q <= 1'b0;
      mask_q   <= '0;
      addr_q   <= '0;
      final_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_pop_q <= is_pop_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      final_q  <= final_d;
      err_q    <= err_d;
    end
  end

  assign in_xfer = (state_q == S_XFER);
  assign in_done = (state_q == S_DONE);
  assign is_pc   = (item == 4'd8);
  assign ack_wb  = in_xfer && is_pop_q && bus.mem_ack;

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = in_done;
  assign bus.sp_out    = in_done ? final_q : '0;
  assign bus.err       = in_done && err_q;
  assign bus.mem_req   = in_xfer;
  assign bus.mem_we    = in_xfer && !is_pop_q;
  assign bus.mem_addr  = in_xfer ? addr_q : '0;
  assign bus.mem_wdata = (in_xfer && !is_pop_q) ? (is_pc ? DATA_W'(bus.lr_in) : bus.rf_rdata) : '0;
  assign bus.rf_raddr  = (in_xfer && !is_pop_q && !is_pc) ? item[2:0] : '0;
  assign bus.rf_we     = ack_wb && !is_pc;
  assign bus.rf_waddr  = bus.rf_we ? item[2:0] : '0;
  assign bus.rf_wdata  = bus.rf_we ? bus.mem_rdata : '0;
  assign bus.pc_we     = ack_wb && is_pc;
  assign bus.pc_out    = bus.pc_we ? bus.mem_rdata[15:0] : '0;
endmodule

// File: doc/st_multi_xfer.md
Name: st_multi_xfer

Overview:
- Execution engine for multi-register PUSH/POP. The stack-top decoder recognises the instruction; this block performs the transfers.
- On a start pulse it turns a 9-bit register list into a sequence of word transfers on the data-memory port.
  - PUSH: stores via register-file reads.
  - POP: loads with register-file and PC writebacks.
- Returns the final stack pointer with a done pulse.

Parameters:
- ADDR_W, 16, data-memory address and SP width.
- DATA_W, 32, data-memory word and register width.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  command strobe; accepted only when busy=0.
- is_pop  input  1  0=PUSH, 1=POP; sampled with start.
- rlist  input  9  register list; [7:0]=R7..R0; [8]=LR on PUSH, PC on POP.
- sp_in  input  ADDR_W  current SP; sampled with start.
- lr_in  input  16  link register value, stored for PUSH bit 8.
- busy  output  1  high from the cycle after accepted start through the done cycle.
- done  output  1  one-cycle completion pulse.
- sp_out  output  ADDR_W  final SP; valid when done=1, else 0.
- err  output  1  alignment abort flag, qualified by done.
- mem_req  output  1  transfer request.
- mem_we  output  1  1=store, 0=load.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  DATA_W  store data.
- mem_ack  input  1  transfer complete; load data valid this cycle.
- mem_rdata  input  DATA_W  load data.
- rf_raddr  output  3  register-file read address (PUSH).
- rf_rdata  input  DATA_W  combinational register read data.
- rf_we  output  1  register writeback strobe (POP).
- rf_waddr  output  3  writeback register.
- rf_wdata  output  DATA_W  writeback data.
- pc_we  output  1  PC write strobe (POP with bit 8).
- pc_out  output  16  PC value to write.

Behaviour:
- Reset (async, resetn=0): state IDLE. Every output is 0. Pending mask, address and SP registers are cleared.
- States: IDLE, XFER, DONE.
- IDLE, start=1:
  - Latch is_pop and rlist into the pending mask.
  - n = popcount(rlist).
  - PUSH: addr = sp_in - 4n, final = sp_in - 4n.
  - POP: addr = sp_in, final = sp_in + 4n.
  - Go to XFER, or directly to DONE if n=0.
- XFER:
  - Current item = lowest set bit of the pending mask, so transfer order is ascending (R0 first, bit 8 last).
  - mem_req=1; mem_addr=addr; mem_we=!is_pop.
  - PUSH: rf_raddr = item index; mem_wdata = rf_rdata, or zero-extended lr_in for bit 8.
  - mem_req, mem_addr, mem_we and mem_wdata stay stable until mem_ack.
  - On mem_ack:
    - Clear the item bit; addr += 4.
    - POP: in the same cycle, pulse rf_we with rf_waddr=item and rf_wdata=mem_rdata. For bit 8, pulse pc_we with pc_out=mem_rdata[15:0] instead.
    - If the mask is now empty, go to DONE; mem_req drops the next cycle.
- DONE: done=1 and sp_out=final for one cycle, then IDLE.
- Latency:
  - Start accepted at cycle t; first request at t+1.
  - With zero-wait ack, done at t+n+1.
  - Empty list: done at t+1.
- start while busy is ignored.
- mem_ack outside XFER is ignored.
- Address and SP arithmetic is modulo 2^ADDR_W (wrap-around allowed).
- Reset mid-transfer: immediate IDLE. No further request or writeback; a pending ack is discarded.

Optional Feature:
- ST_XFER_ALIGN_CHK_EN defined:
  - start with sp_in[1:0]!=0 goes straight to DONE with err=1 and sp_out=sp_in.
  - No mem_req, rf_we or pc_we is issued.
- Undefined: sp_in low bits are used as-is and err is tied to 0.

Test Plan:
- PUSH rlist=0x003, sp_in=0x0100, R0=0xAAAA0000, R1=0xBBBB1111, ack same cycle:
  - Stores 0xAAAA0000 @0x00F8, then 0xBBBB1111 @0x00FC.
  - done at t+3 with sp_out=0x00F8.
- POP rlist=0x101, sp_in=0x00F8, rdata 0x11111111 then 0x00002345:
  - rf_we R0=0x11111111 at 0x00F8.
  - pc_we pc_out=0x2345 at 0x00FC.
  - sp_out=0x0100.
- rlist=0x000 either direction, sp_in=0x0200:
  - done at t+1 with sp_out=0x0200.
  - mem_req never asserted.
- PUSH rlist=0x100 with lr_in=0x1234 and mem_ack delayed 3 cycles:
  - mem_req/addr/wdata=0x00001234 held for 4 cycles.
  - A start pulse during this is ignored.
- PUSH rlist=0x001, sp_in=0x0000: store @0xFFFC, sp_out=0xFFFC.
- resetn low on the 2nd XFER cycle of a 3-register POP: all outputs 0, IDLE. With ST_XFER_ALIGN_CHK_EN, sp_in=0x0102: done, err=1, no mem_req.
